// File: rtl/sfifo_sched_pkg.sv
// ---------------------------------------------------------------------------
// sfifo_sched_pkg : shared types for the FIFO drain scheduler
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sfifo_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sfifo_drain_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin search, first request at/after i_ptr
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
    parameter int G_N = 4,
    parameter int G_W = 2
) (
    input  logic [G_N-1:0] i_req,
    input  logic [G_W-1:0] i_ptr,
    output logic           o_valid,
    output logic [G_W-1:0] o_idx
);

    int w_best;
    int w_dist;

    // Wrap-around distance from the pointer; smallest distance wins.
    always_comb begin
        w_best = G_N;
        w_dist = 0;
        o_idx  = '0;
        for (int i = 0; i < G_N; i++) begin
            w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + G_N - int'(i_ptr));
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = G_W'(i);
            end
        end
        o_valid = (w_best < G_N);
    end

endmodule

`default_nettype wire

// File: rtl/sfifo_drain_sched.sv
// ---------------------------------------------------------------------------
// sfifo_drain_sched : round-robin burst drain scheduler for a FIFO bank
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sfifo_drain_sched
    import sfifo_sched_pkg::*;
#(
    parameter int G_NUM_FIFOS = 4,
    parameter int G_BURST_LEN = 16,
    parameter int G_TIMEOUT   = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_enable,
    input  logic [G_NUM_FIFOS-1:0]         i_fifo_empty,
    input  logic [G_NUM_FIFOS-1:0]         i_fifo_halffull,
    input  logic                           i_out_ready,
    output logic [G_NUM_FIFOS-1:0]         o_rd_en,
    output logic                           o_out_valid,
    output logic [$clog2(G_NUM_FIFOS)-1:0] o_out_sel,
    output logic                           o_busy,
    output logic                           o_burst_done
);

    localparam int SEL_W  = $clog2(G_NUM_FIFOS);
    localparam int BEAT_W = $clog2(G_BURST_LEN + 1);
    localparam int AGE_W  = $clog2(G_TIMEOUT + 1);
    localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(G_NUM_FIFOS - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [SEL_W-1:0]         r_sel;
    logic [SEL_W-1:0]         r_ptr;
    logic [SEL_W-1:0]         r_out_sel;
    logic [SEL_W-1:0]         w_pick_idx;
    logic [BEAT_W-1:0]        r_beats;
    logic [AGE_W-1:0]         r_age [G_NUM_FIFOS];
    logic [G_NUM_FIFOS-1:0]   w_elig;
    logic [G_NUM_FIFOS-1:0]   w_age_clr;
    logic [G_NUM_FIFOS-1:0]   w_rd_en;
    logic                     w_pick_valid;
    logic                     w_grant;
    logic                     w_issue;
    logic                     w_exit;
    logic                     r_out_valid;
    logic                     r_burst_done;

    for (genvar i = 0; i < G_NUM_FIFOS; i++) begin : g_elig
        assign w_elig[i]    = !i_fifo_empty[i] &&
                              (i_fifo_halffull[i] || (r_age[i] >= AGE_W'(G_TIMEOUT)));
        // Age restarts when the FIFO is served, including the grant cycle itself.
        assign w_age_clr[i] = i_fifo_empty[i] ||
                              ((r_state == DRAIN) && (r_sel == SEL_W'(i))) ||
                              (w_grant && (w_pick_idx == SEL_W'(i)));
    end

    rr_pick #(
        .G_N (G_NUM_FIFOS),
        .G_W (SEL_W)
    ) u_pick (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_issue      = 1'b0;
        w_exit       = 1'b0;
        w_rd_en      = '0;
        case (r_state)
            IDLE: begin
                if (i_enable && w_pick_valid) begin
                    w_grant      = 1'b1;
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_issue        = i_out_ready && !i_fifo_empty[r_sel];
                w_rd_en[r_sel] = w_issue;
                w_exit         = i_fifo_empty[r_sel] ||
                                 (w_issue && (r_beats == BEAT_W'(G_BURST_LEN - 1)));
                if (w_exit) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_ptr        <= '0;
            r_beats      <= '0;
            r_out_valid  <= 1'b0;
            r_out_sel    <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_out_valid  <= |w_rd_en;
            r_out_sel    <= r_sel;
            r_burst_done <= w_exit;
            if (w_grant) begin
                r_sel   <= w_pick_idx;
                r_beats <= '0;
            end
            if (w_issue) begin
                r_beats <= r_beats + 1'b1;
            end
            if (w_exit) begin
                r_beats <= '0;
                r_ptr   <= (r_sel == c_last_idx) ? '0 : r_sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < G_NUM_FIFOS; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < G_NUM_FIFOS; i++) begin
                if (w_age_clr[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_W'(G_TIMEOUT)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    assign o_rd_en      = w_rd_en;
    assign o_out_valid  = r_out_valid;
    assign o_out_sel    = r_out_sel;
    assign o_busy       = (r_state == DRAIN);
    assign o_burst_done = r_burst_done;

endmodule

`default_nettype wire

// File: tb/tb_sfifo_drain_sched.sv
// ---------------------------------------------------------------------------
// tb_sfifo_drain_sched : directed self-checking bench with a FIFO fill model
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sfifo_drain_sched;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       out_ready;
    logic [3:0] fifo_empty;
    logic [3:0] fifo_halffull;
    logic [3:0] rd_en;
    logic       out_valid;
    logic [1:0] out_sel;
    logic       busy;
    logic       burst_done;

    int cnt [4];
    int n_pass;
    int n_total;
    bit prev_ready;

    sfifo_drain_sched #(
        .G_NUM_FIFOS (4),
        .G_BURST_LEN (16),
        .G_TIMEOUT   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (enable),
        .i_fifo_empty    (fifo_empty),
        .i_fifo_halffull (fifo_halffull),
        .i_out_ready     (out_ready),
        .o_rd_en         (rd_en),
        .o_out_valid     (out_valid),
        .o_out_sel       (out_sel),
        .o_busy          (busy),
        .o_burst_done    (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO depth 32: halffull at 16 or more entries
    task automatic apply_flags();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]    = (cnt[i] == 0);
            fifo_halffull[i] = (cnt[i] >= 16);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        logic [3:0] rd;
        #1;
        rd = rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rd[i]) begin
                if (cnt[i] == 0) chk("underflow", 32'(i), 32'hFFFF_FFFF);
                else cnt[i] = cnt[i] - 1;
            end
        end
        apply_flags();
        #1;
    endtask

    task automatic flush_all();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        apply_flags();
    endtask

    task automatic run_burst(input int sel, input int nreads, input bit on_empty);
        for (int k = 0; k < nreads; k++) begin
            chk("burst_rd_en", 32'(rd_en), 32'(1 << sel));
            chk("burst_busy", 32'(busy), 1);
            if (k > 0) begin
                chk("burst_out_valid", 32'(out_valid), 1);
                chk("burst_out_sel", 32'(out_sel), 32'(sel));
            end
            step();
        end
        if (on_empty) begin
            chk("empty_end_busy", 32'(busy), 1);
            chk("empty_end_rd_en", 32'(rd_en), 0);
            step();
        end
        chk("done_pulse", 32'(burst_done), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rd_en", 32'(rd_en), 0);
        chk("idle_out_valid", 32'(out_valid), on_empty ? 0 : 1);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        flush_all();
        #2;
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_burst_done", 32'(burst_done), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single halffull FIFO: full 16-beat burst
        enable    = 1'b1;
        out_ready = 1'b1;
        cnt[2]    = 20;
        apply_flags();
        step();
        chk("first_out_valid", 32'(out_valid), 0);
        run_burst(2, 16, 1'b0);
        chk("ptr_after_fifo2", 32'(dut.r_ptr), 3);
        chk("fifo2_left", 32'(cnt[2]), 4);
        flush_all();
        step();
        chk("done_single_cycle", 32'(burst_done), 0);

        // Reset in the middle of a burst (ptr=3 picks FIFO 1)
        cnt[1] = 20;
        apply_flags();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("pre_rst_rd_en", 32'(rd_en), 32'h2);
            step();
        end
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_en", 32'(rd_en), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_done", 32'(burst_done), 0);
        chk("fifo1_after5", 32'(cnt[1]), 15);
        flush_all();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ptr", 32'(dut.r_ptr), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(burst_done), 0);

        // Three halffull FIFOs: grants 0,1,3,0 with one idle cycle between
        cnt[0] = 32;
        cnt[1] = 32;
        cnt[3] = 32;
        apply_flags();
        step();
        run_burst(0, 16, 1'b0);
        step();
        run_burst(1, 16, 1'b0);
        step();
        run_burst(3, 16, 1'b0);
        step();
        run_burst(0, 16, 1'b0);
        flush_all();
        step();

        // Timeout eligibility: FIFO 1 with 3 entries, ptr=1
        cnt[1] = 3;
        apply_flags();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("timeout_wait_busy", 32'(busy), 0);
            chk("timeout_wait_rd_en", 32'(rd_en), 0);
        end
        step();
        run_burst(1, 3, 1'b1);
        chk("fifo1_drained", 32'(cnt[1]), 0);

        // Backpressure: out_ready 1,0,0,1,... on FIFO 2 (ptr=2)
        cnt[2] = 20;
        apply_flags();
        step();
        prev_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            out_ready = !(k == 1 || k == 2);
            #1;
            chk("stall_rd_en", 32'(rd_en), out_ready ? 32'h4 : 32'h0);
            chk("stall_busy", 32'(busy), 1);
            if (k > 0) chk("stall_out_valid", 32'(out_valid), 32'(prev_ready));
            prev_ready = out_ready;
            step();
        end
        out_ready = 1'b1;
        chk("stall_done", 32'(burst_done), 1);
        chk("stall_idle_busy", 32'(busy), 0);
        chk("stall_total_reads", 32'(cnt[2]), 4);
        flush_all();
        step();

        // enable gating: no grants while low; burst completes after mid-burst drop
        enable = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 32;
        apply_flags();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("disabled_rd_en", 32'(rd_en), 0);
            chk("disabled_busy", 32'(busy), 0);
        end
        enable = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            if (k == 3) enable = 1'b0;
            chk("en_drop_rd_en", 32'(rd_en), 32'h8);
            step();
        end
        chk("en_drop_done", 32'(burst_done), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("en_drop_no_grant_busy", 32'(busy), 0);
            chk("en_drop_no_grant_rd", 32'(rd_en), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sfifo_drain_sched.md
# sfifo_drain_sched

Round-robin drain scheduler for a bank of `G_NUM_FIFOS` synchronous FIFOs that use fill-level flag tracking (`empty`, `halffull`). It selects one FIFO at a time and issues a bounded burst of `rd_en` pulses, throttled by a downstream ready signal. It sits between the per-channel FIFOs and a shared single-port consumer, such as a register-bus bridge or a DMA write-out. A FIFO becomes eligible for draining either on fill pressure (`halffull`) or on an age timeout, so no channel can starve.

## Interface
- `G_NUM_FIFOS`, 4: number of FIFOs served; range 2–16.
- `G_BURST_LEN`, 16: maximum reads per grant; must be ≥1.
- `G_TIMEOUT`, 256: cycles a non-empty, non-halffull FIFO waits before it becomes eligible; must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  allows new grants; a burst already in progress always completes.
- `fifo_empty`  in  G_NUM_FIFOS  per-FIFO registered empty flag.
- `fifo_halffull`  in  G_NUM_FIFOS  per-FIFO registered half-full flag.
- `out_ready`  in  1  consumer can take a beat issued this cycle.
- `rd_en`  out  G_NUM_FIFOS  one-hot read strobe to the FIFOs; combinational.
- `out_valid`  out  1  read data from the FIFO on `out_sel` is present this cycle.
- `out_sel`  out  $clog2(G_NUM_FIFOS)  FIFO index for the consumer data mux.
- `busy`  out  1  FSM is in DRAIN.
- `burst_done`  out  1  single-cycle pulse when a burst ends.

## Operation
- FSM states are IDLE and DRAIN. The reset state is IDLE.
- Eligibility of FIFO i is `!fifo_empty[i] && (fifo_halffull[i] || age[i] >= G_TIMEOUT)`.
- IDLE:
  - If `enable` is high and any FIFO is eligible, register the grant `sel` and go to DRAIN.
  - `sel` is the first eligible index at or after `ptr`, searched with wrap-around.
  - Halffull and timeout eligibility have equal priority; round-robin alone decides.
- DRAIN:
  - `rd_en[sel] = out_ready && !fifo_empty[sel]`. All other `rd_en` bits are 0.
  - `beats` increments on each issued read.
  - Exit to IDLE after the cycle in which `beats` reaches `G_BURST_LEN`, or in any cycle where `fifo_empty[sel]` is high.
  - On exit: `ptr <= sel+1` (mod `G_NUM_FIFOS`), `beats <= 0`, and `burst_done` pulses in the first IDLE cycle.
  - If `out_ready` is low, the FSM holds in DRAIN with no reads and no timeout; the burst stays owned.
- Age counters:
  - `age[i]` increments while `fifo_empty[i]` is low and i is not the granted FIFO in DRAIN.
  - It saturates at `G_TIMEOUT`.
  - It clears to 0 when `fifo_empty[i]` is high or when i is granted.
- Widths:
  - `beats` is `$clog2(G_BURST_LEN+1)` bits.
  - `age[i]` is `$clog2(G_TIMEOUT+1)` bits.
  - `ptr` and `sel` are `$clog2(G_NUM_FIFOS)` bits. Wrap is explicit, so index values ≥ `G_NUM_FIFOS` never occur.
- The scheduler never asserts `rd_en` to an empty FIFO, so it never causes an underflow.

## Timing
- Reset values: `rd_en=0`, `out_valid=0`, `out_sel=0`, `busy=0`, `burst_done=0`, `ptr=0`, all `age=0`.
  - Assertion is asynchronous, and `rd_en` drops in the same cycle.
  - A burst interrupted by reset is abandoned; no `burst_done` is issued.
- From an eligible FIFO seen in IDLE to its first `rd_en`: 1 cycle.
- Between bursts there is 1 IDLE cycle, which is also the arbitration cycle.
- `out_valid` and `out_sel` are the registered copies of `|rd_en` and `sel`, delayed 1 cycle to match non-FWFT FIFO read latency.
  - The consumer must accept every `out_valid` beat; `out_ready` governs issue only.
- If a FIFO empties mid-burst, the `fifo_empty` registered flag reaches the scheduler in the cycle after the last read. The burst ends in that cycle and no extra `rd_en` is issued.
- If `enable` is deasserted during DRAIN, the burst completes, and then the FSM stays in IDLE.

## Structure
- Package `sfifo_sched_pkg` holds the state enum typedef (`IDLE`, `DRAIN`).
- The next-index search is a natural sub-module: `rr_pick`. It is combinational, with request vector and pointer in, and valid plus index out.
- The top level contains the FSM, the beat counter, the age-counter array and the output registers.

## Test plan
- FIFO 2 halffull with 20 entries, `out_ready=1` → 16 consecutive `rd_en[2]` starting 1 cycle after grant. `out_valid` lags by 1 cycle. Then `burst_done` pulses and `ptr=3`.
- FIFOs 0, 1 and 3 all halffull → grants occur in order 0, 1, 3, 0. Each pair of bursts is separated by exactly 1 IDLE cycle.
- FIFO 1 holds 3 entries and is not halffull, `G_TIMEOUT=8` → no grant for 8 cycles, then exactly 3 reads. The burst ends on `fifo_empty[1]` with no underflow.
- `out_ready` toggles 1,0,0,1 during a burst → `rd_en` follows `out_ready`, `beats` holds during the stalls, and the total still reaches 16.
- `rst` asserted mid-burst at beat 5 → `rd_en`, `busy` and `out_valid` are 0 in the same cycle. After release the FSM is in IDLE with `ptr=0`.
- `enable=0` with all FIFOs halffull → no `rd_en`. Deasserting `enable` mid-burst lets the current burst finish with no new grant.
